// File: rtl/calc_sequencer.sv
// Multi-cycle arithmetic engine for the keypad calculator. Updates on the falling edge of sw_clk.
// Optional build macro CALC_SEQ_MOD_EN enables operator 5 (remainder); otherwise code 5 is rejected as invalid.
module calc_sequencer (
    input  logic        sw_clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] operand1,
    input  logic [31:0] operand2,
    input  logic [2:0]  operator,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [31:0] ans
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXEC,
        S_FIN
    } state_t;

    typedef enum logic [2:0] {
        OP_EQU   = 3'd0,
        OP_TIMES = 3'd1,
        OP_DIV   = 3'd2,
        OP_PLUS  = 3'd3,
        OP_MINUS = 3'd4,
        OP_MOD   = 3'd5,
        OP_BAD6  = 3'd6,
        OP_BAD7  = 3'd7
    } op_t;

    localparam logic [31:0] ERR_WORD = 32'h00EE_0000;
    localparam logic [63:0] POS_LIMIT = 64'd99_999_999;
    localparam logic [63:0] NEG_LIMIT = 64'd9_999_999;

    state_t      state, state_nx;
    logic        busy_nx, done_nx, err_nx;
    logic [31:0] ans_nx;
    logic        load, step;

    // Captured request
    op_t         opr;
    logic [31:0] op1, op2;
    logic        bad;
    logic [5:0]  cnt;

    // Add/subtract path
    logic [32:0] sum, sum_nx, sum_abs;

    // Shift-add multiplier
    logic [63:0] acc, mcand;
    logic [31:0] mplier;

    // Restoring divider
    logic [32:0] rem, dvsr;
    logic [31:0] quo;
    logic [33:0] shifted, diff;
    logic        ge;

    logic        in_bad;
    logic [32:0] ext1, ext2, mag1, mag2;
    logic        res_neg, range_ok;
    logic [63:0] res_mag;
    logic [31:0] val_mag, val;
    logic        iter_op;

    assign ext1 = {operand1[31], operand1};
    assign ext2 = {operand2[31], operand2};
    assign mag1 = ext1[32] ? (~ext1 + 33'd1) : ext1;
    assign mag2 = ext2[32] ? (~ext2 + 33'd1) : ext2;

    always_comb begin
        in_bad = 1'b0;
        case (op_t'(operator))
            OP_DIV:  in_bad = (operand2 == '0);
`ifdef CALC_SEQ_MOD_EN
            OP_MOD:  in_bad = (operand2 == '0);
`else
            OP_MOD:  in_bad = 1'b1;
`endif
            OP_BAD6: in_bad = 1'b1;
            OP_BAD7: in_bad = 1'b1;
            default: in_bad = 1'b0;
        endcase
    end

    always_comb begin
        case (opr)
            OP_PLUS:  sum_nx = {op1[31], op1} + {op2[31], op2};
            OP_MINUS: sum_nx = {op1[31], op1} - {op2[31], op2};
            default:  sum_nx = {op1[31], op1};
        endcase
    end

    // Bit 33 of diff is the borrow because both operands stay below 2^33.
    assign shifted = {rem, quo[31]};
    assign diff    = shifted - {1'b0, dvsr};
    assign ge      = ~diff[33];

    assign iter_op = (opr == OP_TIMES) || (opr == OP_DIV) || (opr == OP_MOD);

    // Result kept as sign + magnitude so the range check covers the full product width.
    assign sum_abs = sum[32] ? (~sum + 33'd1) : sum;

    always_comb begin
        res_neg = sum[32];
        res_mag = {31'b0, sum_abs};
        case (opr)
            OP_TIMES: begin
                res_neg = op1[31] ^ op2[31];
                res_mag = acc;
            end
            OP_DIV: begin
                res_neg = op1[31] ^ op2[31];
                res_mag = {32'b0, quo};
            end
`ifdef CALC_SEQ_MOD_EN
            OP_MOD: begin
                res_neg = op1[31];
                res_mag = {31'b0, rem};
            end
`endif
            default: ;
        endcase
    end

    assign range_ok = res_neg ? (res_mag <= NEG_LIMIT) : (res_mag <= POS_LIMIT);
    assign val_mag  = res_mag[31:0];
    assign val      = res_neg ? (~val_mag + 32'd1) : val_mag;

    always_comb begin
        state_nx = state;
        busy_nx  = busy;
        done_nx  = 1'b0;
        ans_nx   = ans;
        err_nx   = err;
        load     = 1'b0;
        step     = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    load     = 1'b1;
                    busy_nx  = 1'b1;
                    state_nx = in_bad ? S_FIN : S_EXEC;
                end
            end
            S_EXEC: begin
                step = 1'b1;
                if (!iter_op || cnt == 6'd31)
                    state_nx = S_FIN;
            end
            S_FIN: begin
                done_nx  = 1'b1;
                busy_nx  = 1'b0;
                state_nx = S_IDLE;
                if (bad || !range_ok) begin
                    err_nx = 1'b1;
                    ans_nx = ERR_WORD;
                end else begin
                    err_nx = 1'b0;
                    ans_nx = val;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(negedge sw_clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            err   <= 1'b0;
            ans   <= '0;
        end else begin
            state <= state_nx;
            busy  <= busy_nx;
            done  <= done_nx;
            err   <= err_nx;
            ans   <= ans_nx;
        end
    end

    always_ff @(negedge sw_clk or negedge rst) begin
        if (!rst) begin
            opr    <= OP_EQU;
            op1    <= '0;
            op2    <= '0;
            bad    <= 1'b0;
            cnt    <= '0;
            sum    <= '0;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            rem    <= '0;
            quo    <= '0;
            dvsr   <= '0;
        end else if (load) begin
            opr    <= op_t'(operator);
            op1    <= operand1;
            op2    <= operand2;
            bad    <= in_bad;
            cnt    <= '0;
            acc    <= '0;
            mcand  <= {31'b0, mag1};
            mplier <= mag2[31:0];
            rem    <= '0;
            quo    <= mag1[31:0];
            dvsr   <= mag2;
        end else if (step) begin
            cnt    <= cnt + 6'd1;
            sum    <= sum_nx;
            if (mplier[0])
                acc <= acc + mcand;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            rem    <= ge ? diff[32:0] : shifted[32:0];
            quo    <= {quo[30:0], ge};
        end
    end

endmodule

// File: tb/tb_calc_sequencer.sv
// Self-checking bench for calc_sequencer: directed cases plus randomized operations against
// a plain-arithmetic reference model. Honours CALC_SEQ_MOD_EN the same way as the design.
module tb_calc_sequencer;

    logic        sw_clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] operand1 = '0;
    logic [31:0] operand2 = '0;
    logic [2:0]  operator = '0;
    logic        busy, done, err;
    logic [31:0] ans;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] prev_ans = '0;
    logic        prev_err = 1'b0;

    always #5 sw_clk = ~sw_clk;

    calc_sequencer dut (
        .sw_clk   (sw_clk),
        .rst      (rst),
        .start    (start),
        .operand1 (operand1),
        .operand2 (operand2),
        .operator (operator),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .ans      (ans)
    );

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference: exact signed arithmetic, then display range check.
    function automatic void model(input logic [2:0] opc, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output logic e, output int lat);
        logic signed [63:0] sa, sb, v;
        logic pre_bad;
        sa = 64'($signed(a));
        sb = 64'($signed(b));
        v = '0;
        pre_bad = 1'b0;
        case (opc)
            3'd0: v = sa;
            3'd1: v = sa * sb;
            3'd2: if (sb == 0) pre_bad = 1'b1; else v = sa / sb;
            3'd3: v = sa + sb;
            3'd4: v = sa - sb;
`ifdef CALC_SEQ_MOD_EN
            3'd5: if (sb == 0) pre_bad = 1'b1; else v = sa % sb;
`else
            3'd5: pre_bad = 1'b1;
`endif
            default: pre_bad = 1'b1;
        endcase
        if (pre_bad) lat = 1;
        else if (opc == 3'd1 || opc == 3'd2 || opc == 3'd5) lat = 33;
        else lat = 2;
        e = pre_bad || (v < -64'sd9_999_999) || (v > 64'sd99_999_999);
        r = e ? 32'h00EE_0000 : v[31:0];
    endfunction

    task automatic run_op(input string name, input logic [2:0] opc, input logic [31:0] a,
                          input logic [31:0] b, input int poke_at, input bit scramble);
        logic [31:0] e_ans;
        logic        e_err;
        int          lat;
        int          seen;
        model(opc, a, b, e_ans, e_err, lat);
        @(posedge sw_clk);
        operand1 = a;
        operand2 = b;
        operator = opc;
        start    = 1'b1;
        @(negedge sw_clk);
        @(posedge sw_clk);
        start = 1'b0;
        if (scramble) begin
            operand1 = $urandom;
            operand2 = $urandom;
            operator = 3'($urandom_range(0, 7));
        end
        checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL %s busy_after_start: busy=%b done=%b, want busy=1 done=0", name, busy, done);
        end
        seen = 0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge sw_clk);
            start = 1'b0;
            if (done === 1'b1) begin
                seen = k;
                break;
            end
            checks++;
            if (busy !== 1'b1 || ans !== prev_ans || err !== prev_err) begin
                errors++;
                $display("FAIL %s hold_cycle%0d: busy=%b ans=%h err=%b, want busy=1 ans=%h err=%b",
                         name, k, busy, ans, err, prev_ans, prev_err);
            end
            if (k == poke_at) begin
                start    = 1'b1;
                operand1 = $urandom;
                operand2 = $urandom;
                operator = 3'd3;
            end
        end
        checks++;
        if (seen != lat) begin
            errors++;
            $display("FAIL %s latency: done after N+%0d, want N+%0d", name, seen, lat);
        end
        if (seen != 0) begin
            checks++;
            if (ans !== e_ans) begin
                errors++;
                $display("FAIL %s ans: got %h, want %h", name, ans, e_ans);
            end
            checks++;
            if (err !== e_err) begin
                errors++;
                $display("FAIL %s err: got %b, want %b", name, err, e_err);
            end
            checks++;
            if (busy !== 1'b0) begin
                errors++;
                $display("FAIL %s busy_at_done: got %b, want 0", name, busy);
            end
            @(posedge sw_clk);
            checks++;
            if (done !== 1'b0 || ans !== e_ans) begin
                errors++;
                $display("FAIL %s done_pulse: done=%b ans=%h, want done=0 ans=%h", name, done, ans, e_ans);
            end
        end
        prev_ans = e_ans;
        prev_err = e_err;
    endtask

    function automatic logic [31:0] rnd_operand();
        logic [31:0] bv [10];
        logic [31:0] v;
        bv = '{32'd0, 32'd1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF,
               32'd99_999_999, 32'd100_000_000, -32'd9_999_999, -32'd10_000_000, 32'd7};
        case ($urandom_range(0, 3))
            0: v = 32'($urandom_range(0, 20000));
            1: v = $urandom;
            2: v = bv[$urandom_range(0, 9)];
            default: v = 32'($urandom_range(0, 100_000_000));
        endcase
        if ($urandom_range(0, 1) == 1) v = -v;
        return v;
    endfunction

    task automatic test_reset();
        #2 rst = 1'b0;
        repeat (3) @(posedge sw_clk);
        checks++;
        if (ans !== 32'd0 || err !== 1'b0 || done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_values: ans=%h err=%b done=%b busy=%b, want all 0", ans, err, done, busy);
        end
        rst = 1'b1;
        prev_ans = '0;
        prev_err = 1'b0;
    endtask

    task automatic test_add_sub();
        run_op("plus_123_m456", 3'd3, 32'd123, -32'd456, 0, 1'b0);
        run_op("minus", 3'd4, 32'd5000, 32'd12345, 0, 1'b0);
        run_op("equ_neg", 3'd0, -32'd77, 32'd9, 0, 1'b0);
        run_op("plus_pos_edge", 3'd3, 32'd99_999_998, 32'd1, 0, 1'b0);
        run_op("plus_pos_over", 3'd3, 32'd99_999_999, 32'd1, 0, 1'b0);
        run_op("minus_neg_edge", 3'd4, -32'd9_999_998, 32'd1, 0, 1'b0);
        run_op("minus_neg_over", 3'd4, -32'd9_999_999, 32'd1, 0, 1'b0);
        run_op("plus_wrap", 3'd3, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 0, 1'b0);
    endtask

    task automatic test_times();
        run_op("times_9999sq", 3'd1, 32'd9999, 32'd9999, 0, 1'b0);
        run_op("times_over", 3'd1, 32'd999_999, 32'd999, 0, 1'b0);
        run_op("times_neg", 3'd1, -32'd3162, 32'd3162, 0, 1'b0);
        run_op("times_zero_neg", 3'd1, 32'd0, -32'd5, 0, 1'b0);
        run_op("times_min", 3'd1, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1'b0);
    endtask

    task automatic test_div_mod();
        run_op("div_m100_7", 3'd2, -32'd100, 32'd7, 0, 1'b0);
        run_op("mod_m100_7", 3'd5, -32'd100, 32'd7, 0, 1'b0);
        run_op("div_neg_neg", 3'd2, -32'd99_999_999, -32'd3, 0, 1'b0);
        run_op("mod_pos_neg", 3'd5, 32'd100, -32'd7, 0, 1'b0);
        run_op("div_min_m1", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1'b0);
        run_op("div_min_big", 3'd2, 32'h8000_0000, 32'd1000, 0, 1'b0);
    endtask

    task automatic test_div_zero();
        run_op("div_5_0", 3'd2, 32'd5, 32'd0, 0, 1'b0);
        run_op("plus_after_err", 3'd3, 32'd1, 32'd1, 0, 1'b0);
        run_op("mod_x_0", 3'd5, 32'd9, 32'd0, 0, 1'b0);
        run_op("op6", 3'd6, 32'd1, 32'd2, 0, 1'b0);
        run_op("op7", 3'd7, 32'd3, 32'd4, 0, 1'b0);
    endtask

    task automatic test_ignore_start();
        run_op("times_poke", 3'd1, 32'd1234, 32'd5678, 5, 1'b0);
        for (int k = 0; k < 3; k++) begin
            @(posedge sw_clk);
            checks++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL ignore_start_idle%0d: done=%b busy=%b, want 0 0", k, done, busy);
            end
        end
    endtask

    task automatic test_reset_abort();
        int dones;
        run_op("pre_abort_plus", 3'd3, 32'd1000, 32'd234, 0, 1'b0);
        @(posedge sw_clk);
        operand1 = -32'd100;
        operand2 = 32'd7;
        operator = 3'd2;
        start    = 1'b1;
        @(negedge sw_clk);
        @(posedge sw_clk);
        start = 1'b0;
        repeat (9) @(posedge sw_clk);
        rst = 1'b0;
        #1;
        checks++;
        if (ans !== 32'd0 || err !== 1'b0 || done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_reset: ans=%h err=%b done=%b busy=%b, want all 0", ans, err, done, busy);
        end
        repeat (2) @(posedge sw_clk);
        rst = 1'b1;
        prev_ans = '0;
        prev_err = 1'b0;
        dones = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge sw_clk);
            if (done === 1'b1 || busy === 1'b1) dones++;
        end
        checks++;
        if (dones != 0) begin
            errors++;
            $display("FAIL abort_no_done: %0d cycles with done/busy, want 0", dones);
        end
        run_op("equ_42", 3'd0, 32'd42, 32'd0, 0, 1'b0);
    endtask

    task automatic test_random(input int n);
        logic [2:0]  opc;
        logic [31:0] a, b;
        for (int i = 0; i < n; i++) begin
            opc = 3'($urandom_range(0, 7));
            a = rnd_operand();
            b = rnd_operand();
            run_op($sformatf("rand%0d_op%0d", i, opc), opc, a, b, 0, 1'b1);
        end
    endtask

    initial begin
        test_reset();
        test_add_sub();
        test_times();
        test_div_mod();
        test_div_zero();
        test_ignore_start();
        test_reset_abort();
        test_random(60);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
